// File: rtl/bcd_pkg.sv
// bcd_pkg
// Shared types and constants for the BCD scan driver and its add-3 helper.
//   CODE_DASH   : decoder code rendered as a minus sign
//   CODE_BLANK  : decoder code rendered as an unlit digit
//   state_t     : conversion FSM states
//   bcd_digit_t : one BCD nibble
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t CODE_DASH  = 4'd10;
  localparam bcd_digit_t CODE_BLANK = 4'd11;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    LATCH
  } state_t;

endpackage

// File: rtl/dd_add3.sv
// dd_add3
// Double-dabble correction step for one BCD nibble: a nibble of 5 or more
// gets 3 added so that the following left shift carries correctly into the
// next decimal digit.
// Ports:
//   din  : nibble before correction
//   dout : nibble after correction
module dd_add3
  import bcd_pkg::*;
(
  input  bcd_digit_t din,
  output bcd_digit_t dout
);

  // Nibbles 5..9 become 8..12 so that doubling them produces a decimal carry.
  always_comb begin
    dout = din;
    if (din >= 4'd5) dout = din + 4'd3;
  end

endmodule

// File: rtl/bcd_scan_driver.sv
// bcd_scan_driver
// Converts a signed two's-complement value to BCD with a sequential
// double-dabble engine (one input bit per clock) and time-multiplexes the
// result across NDIG common-anode digits feeding a BCD-to-7-segment decoder.
// Optional feature macro: BCDSCAN_LZB_EN
//   defined   : leading-zero blanking with a floating minus sign
//   undefined : fixed-width digits, sign (or blank) in the top position
// Ports:
//   clk   : system clock
//   rst   : synchronous active-high reset
//   value : signed value to display (WIDTH bits)
//   load  : strobe, accepted only while busy is low
//   busy  : conversion in progress
//   done  : one-cycle pulse in the cycle the new value is latched
//   bcd   : decoder code (0-9 digit, 10 dash, 11 blank), registered
//   an    : active-low anode enables, exactly one low, registered
module bcd_scan_driver
  import bcd_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int NDIG     = 4,
  parameter int SCAN_DIV = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] value,
  input  logic             load,
  output logic             busy,
  output logic             done,
  output logic [3:0]       bcd,
  output logic [NDIG-1:0]  an
);

  // The top digit position is reserved for the sign in fixed-width mode and
  // is never needed for magnitude digits, so NDIG-1 BCD nibbles suffice.
  localparam int NBCD = NDIG - 1;
  localparam int SRW  = 4 * NBCD;
  localparam int CW   = $clog2(WIDTH + 1);
  localparam int PW   = $clog2(SCAN_DIV);
  localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  state_t           state;
  logic [CW-1:0]    iter;
  logic [WIDTH-1:0] mag;
  logic [SRW-1:0]   bcd_sr;
  logic [SRW-1:0]   bcd_adj;
  logic             conv_sign;
  logic [SRW-1:0]   disp_digits;
  logic             disp_sign;
  logic [PW-1:0]    prescale;
  logic [IW-1:0]    scan_idx;
  logic [WIDTH-1:0] load_mag;
  logic [4*NDIG-1:0] disp_pad;
  bcd_digit_t       cur_digit;
  bcd_digit_t       slot_code;

  // Magnitude is kept at full WIDTH so the most negative input (-2^(WIDTH-1))
  // maps to its correct unsigned magnitude.
  assign load_mag = value[WIDTH-1] ? ((~value) + {{(WIDTH-1){1'b0}}, 1'b1}) : value;

  // One add-3 corrector per BCD nibble, applied before every shift.
  for (genvar g = 0; g < NBCD; g++) begin : g_add3
    dd_add3 u_add3 (
      .din  (bcd_sr[4*g +: 4]),
      .dout (bcd_adj[4*g +: 4])
    );
  end

  // Conversion FSM. done is raised on the transition into LATCH so that it is
  // high exactly during the LATCH cycle; the display registers update at the
  // end of that cycle, so the old contents stay visible until then.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      iter        <= '0;
      mag         <= '0;
      bcd_sr      <= '0;
      conv_sign   <= 1'b0;
      disp_digits <= '0;
      disp_sign   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (load) begin
            // A zero magnitude never carries a sign.
            conv_sign <= value[WIDTH-1] & (|load_mag);
            mag       <= load_mag;
            bcd_sr    <= '0;
            iter      <= '0;
            busy      <= 1'b1;
            state     <= CONV;
          end
        end
        CONV: begin
          // The corrected nibbles shift left taking in the magnitude MSB; the
          // carry out of the top nibble is always zero given the sizing.
          bcd_sr <= SRW'({bcd_adj, mag[WIDTH-1]});
          mag    <= mag << 1;
          if (iter == CW'(WIDTH - 1)) begin
            state <= LATCH;
            done  <= 1'b1;
          end else begin
            iter <= iter + 1'b1;
          end
        end
        LATCH: begin
          disp_digits <= bcd_sr;
          disp_sign   <= conv_sign;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Free-running scan prescaler; each wrap advances to the next digit slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      prescale <= '0;
      scan_idx <= '0;
    end else if (prescale == PW'(SCAN_DIV - 1)) begin
      prescale <= '0;
      scan_idx <= (scan_idx == IW'(NDIG - 1)) ? '0 : scan_idx + 1'b1;
    end else begin
      prescale <= prescale + 1'b1;
    end
  end

  // A zero nibble pads the digit vector so the current slot can always be
  // selected, including the top (sign-only) position.
  assign disp_pad  = {4'd0, disp_digits};
  assign cur_digit = disp_pad[{scan_idx, 2'b00} +: 4];

`ifdef BCDSCAN_LZB_EN
  logic [IW-1:0] msd;

  // msd is the highest non-zero digit position; position 0 is always shown,
  // and the dash floats to the slot just above msd.
  always_comb begin
    msd = '0;
    for (int p = 1; p < NBCD; p++) begin
      if (disp_digits[4*p +: 4] != 4'd0) msd = IW'(p);
    end
    slot_code = CODE_BLANK;
    if (scan_idx <= msd) slot_code = cur_digit;
    else if (disp_sign && (scan_idx == msd + IW'(1))) slot_code = CODE_DASH;
  end
`else
  // Fixed width: every lower position shows its digit (leading zeros kept),
  // the top position carries only the sign.
  always_comb begin
    slot_code = cur_digit;
    if (scan_idx == IW'(NDIG - 1)) slot_code = disp_sign ? CODE_DASH : CODE_BLANK;
  end
`endif

  // Registered outputs to the decoder and anode drivers.
  always_ff @(posedge clk) begin
    if (rst) begin
      an  <= '1;
      bcd <= CODE_BLANK;
    end else begin
      an  <= ~(NDIG'(1) << scan_idx);
      bcd <= slot_code;
    end
  end

endmodule

// File: tb/tb_bcd_scan_driver.sv
// tb_bcd_scan_driver
// Self-checking bench for bcd_scan_driver (WIDTH=8, NDIG=4, SCAN_DIV=4).
// Expected digit codes come from a decimal reference model and are queued
// when a value is loaded, then popped as each scan slot is observed.
// Follows BCDSCAN_LZB_EN the same way as the design.
module tb_bcd_scan_driver;

  localparam int WIDTH    = 8;
  localparam int NDIG     = 4;
  localparam int SCAN_DIV = 4;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] value;
  logic             load;
  logic             busy;
  logic             done;
  logic [3:0]       bcd;
  logic [NDIG-1:0]  an;

  int errors;
  int checks;
  logic [3:0] sbq[$];

  bcd_scan_driver #(
    .WIDTH    (WIDTH),
    .NDIG     (NDIG),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .value (value),
    .load  (load),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd),
    .an    (an)
  );

  // Free-running 10-time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model: decoder code expected at digit position pos for value v.
  function automatic logic [3:0] modelCode(input int v, input int pos);
    int m;
    int p10;
    int nd;
    int t;
    int d;
    m   = (v < 0) ? -v : v;
    p10 = 1;
    for (int i = 0; i < pos; i++) p10 = p10 * 10;
    d  = (m / p10) % 10;
    nd = 1;
    t  = m;
    while (t >= 10) begin
      t  = t / 10;
      nd = nd + 1;
    end
`ifdef BCDSCAN_LZB_EN
    if (pos < nd) return 4'(d);
    if (v < 0 && pos == nd) return 4'd10;
    return 4'd11;
`else
    if (pos == NDIG - 1) return (v < 0) ? 4'd10 : 4'd11;
    return 4'(d);
`endif
  endfunction

  // Queue the expected codes for slots 0..NDIG-1 of value v.
  task automatic pushExpected(input int v);
    for (int p = 0; p < NDIG; p++) sbq.push_back(modelCode(v, p));
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic reportTimeout(input string tag);
    checks++;
    errors++;
    $display("[TB] FAIL %s: observed=timeout required=event", tag);
  endtask

  // Load v; with hold the strobe stays high through the conversion and the
  // input changes to alt mid-way. Checks busy/done timing relative to the
  // load cycle. chain=1 returns in the first busy-low cycle, otherwise one
  // cycle later so the next scan sweep reflects the new display.
  task automatic applyStimulus(input int v, input int alt, input bit push,
                               input bit hold, input bit chain);
    int pulses;
    int budget;
    budget = 100;
    while (busy && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) reportTimeout("busy_wait");
    value = 8'(v);
    load  = 1'b1;
    if (push) pushExpected(v);
    pulses = 0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (done) pulses++;
      if (n == 1) checkOutput("busy_rise", 8'(busy), 8'd1);
      checkOutput($sformatf("done_cycle%0d", n), 8'(done), (n == 9) ? 8'd1 : 8'd0);
      if (n == 10) checkOutput("busy_fall", 8'(busy), 8'd0);
      if (!hold || n >= 9) load = 1'b0;
      if (hold && n == 3) value = 8'(alt);
    end
    checkOutput("done_pulses", 8'(pulses), 8'd1);
    if (!chain) @(negedge clk);
  endtask

  // Align to the start of slot 0 and verify one full sweep against the queue:
  // each anode held for SCAN_DIV cycles, each slot's code as expected.
  task automatic checkScan();
    int budget;
    logic [3:0] expc;
    logic [3:0] exp_an;
    budget = 100;
    while (an == 4'b1110 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    while (an != 4'b1110 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      reportTimeout("scan_align");
      return;
    end
    for (int k = 0; k < NDIG; k++) begin
      exp_an = ~(4'b0001 << k);
      if (sbq.size() == 0) begin
        reportTimeout("scoreboard_empty");
        expc = 4'd11;
      end else begin
        expc = sbq.pop_front();
      end
      for (int c = 0; c < SCAN_DIV; c++) begin
        checkOutput($sformatf("slot%0d_an", k), 8'(an), 8'(exp_an));
        if (c == 0) checkOutput($sformatf("slot%0d_bcd", k), 8'(bcd), 8'(expc));
        @(negedge clk);
      end
    end
  endtask

  // Directed sequence.
  initial begin
    int pulses;
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    load   = 1'b0;
    value  = '0;

    // Reset state, with a load presented during reset that must be ignored.
    repeat (2) @(negedge clk);
    load  = 1'b1;
    value = 8'd55;
    @(negedge clk);
    checkOutput("reset_an", 8'(an), 8'hF);
    checkOutput("reset_bcd", 8'(bcd), 8'd11);
    checkOutput("reset_busy", 8'(busy), 8'd0);
    checkOutput("reset_done", 8'(done), 8'd0);
    load = 1'b0;
    rst  = 1'b0;
    pushExpected(0);
    @(negedge clk);
    checkOutput("load_in_reset_ignored", 8'(busy), 8'd0);
    checkScan();

    // Main conversions including the most negative value and inner zeros.
    applyStimulus(127, 0, 1'b1, 1'b0, 1'b0);
    checkScan();
    applyStimulus(-128, 0, 1'b1, 1'b0, 1'b0);
    checkScan();
    applyStimulus(-5, 0, 1'b1, 1'b0, 1'b0);
    checkScan();
    applyStimulus(100, 0, 1'b1, 1'b0, 1'b0);
    checkScan();

    // Strobe held through busy with the input changing: first value only.
    applyStimulus(-37, 64, 1'b1, 1'b1, 1'b0);
    checkScan();

    // Back-to-back: a load in the very cycle busy drops is accepted.
    applyStimulus(64, 0, 1'b0, 1'b0, 1'b1);
    applyStimulus(42, 0, 1'b1, 1'b0, 1'b0);
    checkScan();

    // Reset in the fourth conversion cycle aborts and clears the display.
    value = 8'd99;
    load  = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      load = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_busy", 8'(busy), 8'd0);
    checkOutput("abort_done", 8'(done), 8'd0);
    checkOutput("abort_an", 8'(an), 8'hF);
    checkOutput("abort_bcd", 8'(bcd), 8'd11);
    rst = 1'b0;
    pushExpected(0);
    pulses = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    checkOutput("abort_no_done", 8'(pulses), 8'd0);
    checkOutput("abort_idle", 8'(busy), 8'd0);
    checkScan();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
